// File: rtl/distance_pkg.sv
// Shared constants and helpers for the multi-channel distance sampler.
package distance_pkg;

    localparam int unsigned DIST_DW          = 33;
    localparam int unsigned MAX_DIST_DEFAULT = 400;

    // Channel-index width; a single channel still needs one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/distance_sampler_if.sv
// Result stream from the sampler to the downstream consumer (valid/ready).
interface distance_sampler_if #(
    parameter int unsigned DW = 33,
    parameter int unsigned CW = 2
) ();

    logic          valid;
    logic          ready;
    logic [CW-1:0] channel;
    logic [DW-1:0] distance;
    logic          out_of_range;

    modport master (
        output valid,
        output channel,
        output distance,
        output out_of_range,
        input  ready
    );

    modport slave (
        input  valid,
        input  channel,
        input  distance,
        input  out_of_range,
        output ready
    );

endinterface

// File: rtl/distance_avg.sv
// One channel: clamp, moving-average window with running sum, and a single pending result.
module distance_avg
    import distance_pkg::*;
#(
    parameter int unsigned DW       = DIST_DW,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned MAX_DIST = MAX_DIST_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] distance_i,
    input  logic          read_i,
    input  logic          idle_i,
    input  logic          grant_i,
    output logic          pend_valid_o,
    output logic [DW-1:0] pend_result_o,
    output logic          pend_oor_o,
    output logic          done_read_o,
    output logic          overrun_o
);

    localparam int unsigned WIN = 1 << AVG_LOG2;
    localparam int unsigned SW  = DW + AVG_LOG2;
    localparam logic [DW-1:0] MaxDist = DW'(MAX_DIST);

    logic [DW-1:0] win_q [WIN];
    logic [DW-1:0] win_d [WIN];
    logic [SW-1:0] sum_q, sum_d;
    logic          filled_q, filled_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_oor_q, s1_oor_d;
    logic          pend_valid_q, pend_valid_d;
    logic [DW-1:0] pend_result_q, pend_result_d;
    logic          pend_oor_q, pend_oor_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;

    logic          sample_oor;
    logic [DW-1:0] sample;

    assign sample_oor = distance_i > MaxDist;
    assign sample     = sample_oor ? MaxDist : distance_i;

    always_comb begin
        win_d         = win_q;
        sum_d         = sum_q;
        filled_d      = filled_q;
        s1_valid_d    = 1'b0;
        s1_oor_d      = s1_oor_q;
        pend_valid_d  = pend_valid_q;
        pend_result_d = pend_result_q;
        pend_oor_d    = pend_oor_q;
        done_d        = done_q;
        overrun_d     = overrun_q;

        if (grant_i) pend_valid_d = 1'b0;
        if (s1_valid_q) begin
            if (pend_valid_q && !grant_i) overrun_d = 1'b1;
            pend_valid_d  = 1'b1;
            pend_result_d = DW'(sum_q >> AVG_LOG2);
            pend_oor_d    = s1_oor_q;
        end

        if (idle_i) begin
            for (int i = 0; i < int'(WIN); i++) win_d[i] = '0;
            sum_d        = '0;
            filled_d     = 1'b0;
            pend_valid_d = 1'b0;
            done_d       = 1'b0;
            overrun_d    = 1'b0;
        end

        // A read in the same cycle as idle restarts the window from this sample.
        if (read_i) begin
            if (!filled_q || idle_i) begin
                for (int i = 0; i < int'(WIN); i++) win_d[i] = sample;
                sum_d = SW'(sample) << AVG_LOG2;
            end else begin
                for (int i = int'(WIN) - 1; i > 0; i--) win_d[i] = win_q[i-1];
                win_d[0] = sample;
                sum_d    = sum_q + SW'(sample) - SW'(win_q[WIN-1]);
            end
            filled_d   = 1'b1;
            s1_valid_d = 1'b1;
            s1_oor_d   = sample_oor;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(WIN); i++) win_q[i] <= '0;
            sum_q         <= '0;
            filled_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_oor_q      <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_result_q <= '0;
            pend_oor_q    <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            win_q         <= win_d;
            sum_q         <= sum_d;
            filled_q      <= filled_d;
            s1_valid_q    <= s1_valid_d;
            s1_oor_q      <= s1_oor_d;
            pend_valid_q  <= pend_valid_d;
            pend_result_q <= pend_result_d;
            pend_oor_q    <= pend_oor_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pend_valid_o  = pend_valid_q;
    assign pend_result_o = pend_result_q;
    assign pend_oor_o    = pend_oor_q;
    assign done_read_o   = done_q;
    assign overrun_o     = overrun_q;

endmodule

// File: rtl/distance_sampler.sv
// Per-channel averaging front ends feeding one round-robin arbitrated output register.
module distance_sampler
    import distance_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned DW       = DIST_DW,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned MAX_DIST = MAX_DIST_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*DW-1:0]     i_distance,
    input  logic [CH-1:0]        i_read,
    input  logic [CH-1:0]        i_idle,
    output logic [CH-1:0]        o_done_read,
    output logic [CH-1:0]        o_overrun,
    distance_sampler_if.master   out_if
);

    localparam int unsigned CW = ch_width(CH);

    logic [CH-1:0] pend_valid;
    logic [CH-1:0] pend_oor;
    logic [DW-1:0] pend_result [CH];
    logic [CH-1:0] grant;

    for (genvar c = 0; c < int'(CH); c++) begin : g_ch
        distance_avg #(
            .DW       (DW),
            .AVG_LOG2 (AVG_LOG2),
            .MAX_DIST (MAX_DIST)
        ) u_avg (
            .clk           (clk),
            .rst           (rst),
            .distance_i    (i_distance[c*DW +: DW]),
            .read_i        (i_read[c]),
            .idle_i        (i_idle[c]),
            .grant_i       (grant[c]),
            .pend_valid_o  (pend_valid[c]),
            .pend_result_o (pend_result[c]),
            .pend_oor_o    (pend_oor[c]),
            .done_read_o   (o_done_read[c]),
            .overrun_o     (o_overrun[c])
        );
    end

    logic          valid_q, valid_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [DW-1:0] dist_q, dist_d;
    logic          oor_q, oor_d;
    logic [CW-1:0] ptr_q, ptr_d;

    logic          load;
    logic          found;
    logic [CW-1:0] sel;
    logic [CW-1:0] cand;
    int unsigned   idx;

    always_comb begin
        load  = !valid_q || out_if.ready;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        idx   = 0;
        grant = '0;
        // Scan from the pointer; the first pending channel wins.
        for (int unsigned k = 0; k < CH; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= CH) idx = idx - CH;
            cand = CW'(idx);
            if (!found && pend_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        valid_d = valid_q;
        chan_d  = chan_q;
        dist_d  = dist_q;
        oor_d   = oor_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                grant[sel] = 1'b1;
                chan_d     = sel;
                dist_d     = pend_result[sel];
                oor_d      = pend_oor[sel];
                ptr_d      = (32'(sel) == CH - 1) ? '0 : sel + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            chan_q  <= '0;
            dist_q  <= '0;
            oor_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            chan_q  <= chan_d;
            dist_q  <= dist_d;
            oor_q   <= oor_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_if.valid        = valid_q;
    assign out_if.channel      = chan_q;
    assign out_if.distance     = dist_q;
    assign out_if.out_of_range = oor_q;

endmodule

// File: tb/tb_distance_sampler.sv
// Directed bench for distance_sampler with hand-computed averages and arbitration order.
module tb_distance_sampler;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 33;
    localparam int unsigned CW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*DW-1:0] i_distance;
    logic [CH-1:0]    i_read;
    logic [CH-1:0]    i_idle;
    logic [CH-1:0]    o_done_read;
    logic [CH-1:0]    o_overrun;

    int vec  = 0;
    int miss = 0;

    distance_sampler_if #(.DW(DW), .CW(CW)) out_if ();

    distance_sampler #(
        .CH       (CH),
        .DW       (DW),
        .AVG_LOG2 (2),
        .MAX_DIST (400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_distance  (i_distance),
        .i_read      (i_read),
        .i_idle      (i_idle),
        .o_done_read (o_done_read),
        .o_overrun   (o_overrun),
        .out_if      (out_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int c, input int val);
        i_distance[c*DW +: DW] = 33'(val);
        i_read[c] = 1'b1;
        step();
        i_read = '0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_if.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = '0;
        i_idle = '0;
        i_distance = '0;
        out_if.ready = 1'b0;
        step();
        step();
        vec++;
        if (out_if.valid !== 1'b0) begin
            miss++; $display("FAIL reset_valid: got %0b expected 0", out_if.valid);
        end
        vec++;
        if ({out_if.channel, out_if.distance, out_if.out_of_range} !== '0) begin
            miss++; $display("FAIL reset_data: got ch %0d dist %0d oor %0b expected all 0",
                             out_if.channel, out_if.distance, out_if.out_of_range);
        end
        vec++;
        if ({o_done_read, o_overrun} !== 8'h00) begin
            miss++; $display("FAIL reset_flags: got done %b ovr %b expected 0000 0000",
                             o_done_read, o_overrun);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        out_if.ready = 1'b1;
        do_read(0, 100);
        vec++;
        if (o_done_read !== 4'b0001 || out_if.valid !== 1'b0) begin
            miss++; $display("FAIL lat_cycle1: got done %b valid %0b expected 0001 0",
                             o_done_read, out_if.valid);
        end
        step();
        vec++;
        if (out_if.valid !== 1'b0) begin
            miss++; $display("FAIL lat_cycle2: got valid %0b expected 0", out_if.valid);
        end
        step();
        vec++;
        if (out_if.valid !== 1'b1 || out_if.channel !== 2'd0 || out_if.distance !== 33'd100
            || out_if.out_of_range !== 1'b0) begin
            miss++; $display("FAIL lat_cycle3: got v %0b ch %0d dist %0d oor %0b expected 1 0 100 0",
                             out_if.valid, out_if.channel, out_if.distance, out_if.out_of_range);
        end
        step();
        vec++;
        if (out_if.valid !== 1'b0) begin
            miss++; $display("FAIL lat_accept: got valid %0b expected 0", out_if.valid);
        end
    endtask

    task automatic test_average();
        int vals [3] = '{200, 300, 400};
        int exps [3] = '{125, 175, 250};
        bit ok;
        for (int i = 0; i < 3; i++) begin
            step();
            do_read(0, vals[i]);
            wait_valid(ok);
            vec++;
            if (!ok || out_if.channel !== 2'd0 || out_if.distance !== 33'(exps[i])) begin
                miss++; $display("FAIL avg_%0d: got ok %0b ch %0d dist %0d expected 1 0 %0d",
                                 i, ok, out_if.channel, out_if.distance, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_clamp();
        bit ok;
        do_read(1, 500);
        wait_valid(ok);
        vec++;
        if (!ok || out_if.channel !== 2'd1 || out_if.distance !== 33'd400
            || out_if.out_of_range !== 1'b1) begin
            miss++; $display("FAIL clamp_500: got ok %0b ch %0d dist %0d oor %0b expected 1 1 400 1",
                             ok, out_if.channel, out_if.distance, out_if.out_of_range);
        end
        step();
        do_read(1, 0);
        wait_valid(ok);
        vec++;
        if (!ok || out_if.distance !== 33'd300 || out_if.out_of_range !== 1'b0) begin
            miss++; $display("FAIL clamp_0: got ok %0b dist %0d oor %0b expected 1 300 0",
                             ok, out_if.distance, out_if.out_of_range);
        end
        step();
    endtask

    task automatic test_round_robin();
        int set_a [4] = '{10, 20, 30, 40};
        int exp_b [4] = '{20, 30, 40, 50};
        int set_b [4] = '{50, 60, 70, 80};
        bit ok;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_if.ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) i_distance[c*DW +: DW] = 33'(r == 0 ? set_a[c] : set_b[c]);
            i_read = 4'hf;
            step();
            i_read = '0;
            wait_valid(ok);
            for (int c = 0; c < 4; c++) begin
                vec++;
                if (!ok || out_if.valid !== 1'b1 || out_if.channel !== 2'(c)
                    || out_if.distance !== 33'(r == 0 ? set_a[c] : exp_b[c])) begin
                    miss++; $display("FAIL rr_%0d_%0d: got v %0b ch %0d dist %0d expected 1 %0d %0d",
                                     r, c, out_if.valid, out_if.channel, out_if.distance, c,
                                     r == 0 ? set_a[c] : exp_b[c]);
                end
                step();
            end
            vec++;
            if (out_if.valid !== 1'b0) begin
                miss++; $display("FAIL rr_drain_%0d: got valid %0b expected 0", r, out_if.valid);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        out_if.ready = 1'b0;
        i_idle = 4'b0100;
        step();
        i_idle = '0;
        do_read(2, 10);
        wait_valid(ok);
        step();
        do_read(2, 20);
        step();
        step();
        do_read(2, 30);
        step();
        step();
        step();
        vec++;
        if (!ok || out_if.valid !== 1'b1 || out_if.channel !== 2'd2 || out_if.distance !== 33'd10) begin
            miss++; $display("FAIL ovr_hold: got v %0b ch %0d dist %0d expected 1 2 10",
                             out_if.valid, out_if.channel, out_if.distance);
        end
        vec++;
        if (o_overrun !== 4'b0100) begin
            miss++; $display("FAIL ovr_flag: got %b expected 0100", o_overrun);
        end
        out_if.ready = 1'b1;
        step();
        vec++;
        if (out_if.valid !== 1'b1 || out_if.channel !== 2'd2 || out_if.distance !== 33'd17) begin
            miss++; $display("FAIL ovr_next: got v %0b ch %0d dist %0d expected 1 2 17",
                             out_if.valid, out_if.channel, out_if.distance);
        end
        step();
        vec++;
        if (out_if.valid !== 1'b0) begin
            miss++; $display("FAIL ovr_drain: got valid %0b expected 0", out_if.valid);
        end
        i_idle = 4'b0100;
        step();
        i_idle = '0;
        vec++;
        if (o_overrun[2] !== 1'b0 || o_done_read[2] !== 1'b0) begin
            miss++; $display("FAIL idle_clear: got ovr %0b done %0b expected 0 0",
                             o_overrun[2], o_done_read[2]);
        end
    endtask

    task automatic test_read_idle();
        bit ok;
        i_idle = 4'b1000;
        step();
        i_idle = '0;
        do_read(3, 100);
        wait_valid(ok);
        step();
        do_read(3, 300);
        wait_valid(ok);
        vec++;
        if (!ok || out_if.channel !== 2'd3 || out_if.distance !== 33'd150) begin
            miss++; $display("FAIL ri_prior: got ok %0b ch %0d dist %0d expected 1 3 150",
                             ok, out_if.channel, out_if.distance);
        end
        step();
        i_idle = 4'b1000;
        do_read(3, 40);
        i_idle = '0;
        vec++;
        if (o_done_read[3] !== 1'b1) begin
            miss++; $display("FAIL ri_done: got %0b expected 1", o_done_read[3]);
        end
        wait_valid(ok);
        vec++;
        if (!ok || out_if.channel !== 2'd3 || out_if.distance !== 33'd40) begin
            miss++; $display("FAIL ri_result: got ok %0b ch %0d dist %0d expected 1 3 40",
                             ok, out_if.channel, out_if.distance);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_if.ready = 1'b0;
        do_read(0, 77);
        wait_valid(ok);
        vec++;
        if (!ok) begin
            miss++; $display("FAIL rm_valid: got valid %0b expected 1", out_if.valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec++;
        if (out_if.valid !== 1'b0 || {out_if.channel, out_if.distance, out_if.out_of_range} !== '0
            || {o_done_read, o_overrun} !== 8'h00) begin
            miss++; $display("FAIL rm_clear: got v %0b dist %0d done %b ovr %b expected all 0",
                             out_if.valid, out_if.distance, o_done_read, o_overrun);
        end
        step();
        step();
        vec++;
        if (out_if.valid !== 1'b0) begin
            miss++; $display("FAIL rm_after: got valid %0b expected 0", out_if.valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_average();
        test_clamp();
        test_round_robin();
        test_overrun();
        test_read_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
